// File: rtl/fixed_mult_pkg.sv
// Shared constants and helpers for the fixed-point multiplier datapath:
// rounding/saturation mode encodings, Q-format range limits and a parameter check.
package fixed_mult_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLAMP     = 1;

  function automatic longint max_q(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint min_q(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  function automatic bit params_legal(input int width, input int frac_bits, input int stages,
                                      input int round_en, input int sat_en);
    return (width >= 8) && (width <= 32) &&
           (frac_bits >= 1) && (frac_bits <= width - 2) &&
           (stages >= 3) && (stages <= 6) &&
           ((round_en == ROUND_TRUNC) || (round_en == ROUND_HALF_UP)) &&
           ((sat_en == SAT_WRAP) || (sat_en == SAT_CLAMP));
  endfunction

endpackage

// File: rtl/fixed_mult_pipe_if.sv
// Operand/result handshake bundle of the fixed-point multiplier.
// master = operand producer / result consumer, slave = the multiplier.
interface fixed_mult_pipe_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_in;
  logic signed [WIDTH-1:0] b_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] p_out;
  logic                    ovf_out;
  logic                    ovf_sticky;
  logic                    ovf_clr;

  modport master (
    output in_valid, a_in, b_in, out_ready, ovf_clr,
    input  in_ready, out_valid, p_out, ovf_out, ovf_sticky
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready, ovf_clr,
    output in_ready, out_valid, p_out, ovf_out, ovf_sticky
  );
endinterface

// File: rtl/fixed_round_sat.sv
// Combinational product post-processing: optional round-half-up, arithmetic
// shift by FRAC_BITS, then range check with saturate or wrap.
module fixed_round_sat
  import fixed_mult_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 8,
  parameter int ROUND_EN  = 1,
  parameter int SAT_EN    = 1
) (
  input  logic signed [2*WIDTH-1:0] prod_i,
  output logic signed [WIDTH-1:0]   res_o,
  output logic                      ovf_o
);
  // One extra bit so adding the rounding half can never overflow.
  localparam int EW = 2*WIDTH + 1;
  localparam logic signed [EW-1:0] HALF    = EW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [EW-1:0] RND_ADD = (ROUND_EN == ROUND_HALF_UP) ? HALF : '0;
  localparam logic signed [WIDTH-1:0] MAX_W = WIDTH'(max_q(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_W = WIDTH'(min_q(WIDTH));

  function automatic logic signed [EW-1:0] round_shift(input logic signed [2*WIDTH-1:0] p);
    logic signed [EW-1:0] ext;
    ext = EW'(p) + RND_ADD;
    return ext >>> FRAC_BITS;
  endfunction

  // In range exactly when every bit from the result sign bit upward agrees.
  function automatic logic [WIDTH:0] range_limit(input logic signed [EW-1:0] s);
    logic                    ovf;
    logic signed [WIDTH-1:0] r;
    ovf = !((&s[EW-1:WIDTH-1]) || (~|s[EW-1:WIDTH-1]));
    r   = s[WIDTH-1:0];
    if (ovf && (SAT_EN == SAT_CLAMP)) r = s[EW-1] ? MIN_W : MAX_W;
    return {ovf, r};
  endfunction

  assign {ovf_o, res_o} = range_limit(round_shift(prod_i));

endmodule

// File: rtl/fixed_mult_pipe.sv
// Pipelined signed Q-format multiplier with a single global advance enable:
// the whole pipe moves or freezes together, STAGES cycles accept-to-output.
module fixed_mult_pipe
  import fixed_mult_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 8,
  parameter int STAGES    = 3,
  parameter int ROUND_EN  = 1,
  parameter int SAT_EN    = 1
) (
  input logic              clk,
  input logic              rst_n,
  fixed_mult_pipe_if.slave bus
);
  localparam int PW = 2*WIDTH;
  localparam int ND = STAGES - 2;

  logic                    adv;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [WIDTH-1:0] a_p1_q, a_p1_d, b_p1_q, b_p1_d;
  logic [ND-1:0]           vld_p2_q, vld_p2_d;
  logic signed [PW-1:0]    prod_p2_q [ND];
  logic signed [PW-1:0]    prod_p2_d [ND];
  logic signed [PW-1:0]    prod_full;
  logic signed [WIDTH-1:0] rs_res;
  logic                    rs_ovf;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] p_out_q, p_out_d;
  logic                    ovf_out_q, ovf_out_d;
  logic                    ovf_sticky_q, ovf_sticky_d;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign prod_full    = PW'(a_p1_q) * PW'(b_p1_q);

  fixed_round_sat #(
    .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .ROUND_EN(ROUND_EN), .SAT_EN(SAT_EN)
  ) u_round_sat (
    .prod_i (prod_p2_q[ND-1]),
    .res_o  (rs_res),
    .ovf_o  (rs_ovf)
  );

  always_comb begin
    vld_p1_d    = vld_p1_q;
    a_p1_d      = a_p1_q;
    b_p1_d      = b_p1_q;
    vld_p2_d    = vld_p2_q;
    prod_p2_d   = prod_p2_q;
    out_valid_d = out_valid_q;
    p_out_d     = p_out_q;
    ovf_out_d   = ovf_out_q;
    if (adv) begin
      // stage 1: operand capture
      vld_p1_d = bus.in_valid;
      a_p1_d   = bus.a_in;
      b_p1_d   = bus.b_in;
      // stage 2 .. STAGES-1: full product, then retiming delay line
      vld_p2_d[0]  = vld_p1_q;
      prod_p2_d[0] = prod_full;
      for (int i = 1; i < ND; i++) begin
        vld_p2_d[i]  = vld_p2_q[i-1];
        prod_p2_d[i] = prod_p2_q[i-1];
      end
      // final stage: round/saturate result register
      out_valid_d = vld_p2_q[ND-1];
      p_out_d     = rs_res;
      ovf_out_d   = vld_p2_q[ND-1] & rs_ovf;
    end
    ovf_sticky_d = ovf_sticky_q;
    if (bus.ovf_clr) ovf_sticky_d = 1'b0;
    if (out_valid_q && bus.out_ready && ovf_out_q) ovf_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= '0;
      out_valid_q  <= 1'b0;
      p_out_q      <= '0;
      ovf_out_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      out_valid_q  <= out_valid_d;
      p_out_q      <= p_out_d;
      ovf_out_q    <= ovf_out_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p1_q    <= a_p1_d;
    b_p1_q    <= b_p1_d;
    prod_p2_q <= prod_p2_d;
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.p_out      = p_out_q;
  assign bus.ovf_out    = ovf_out_q;
  assign bus.ovf_sticky = ovf_sticky_q;

  always @(posedge clk) begin
    assert (params_legal(WIDTH, FRAC_BITS, STAGES, ROUND_EN, SAT_EN))
      else $error("fixed_mult_pipe: illegal parameter combination");
  end

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Bench for fixed_mult_pipe: two instances (round+saturate, truncate+wrap) share stimulus;
// directed vector table, sticky/backpressure/reset sequences and a randomized model check.
module tb_fixed_mult_pipe;
  localparam int W      = 32;
  localparam int FRAC   = 8;
  localparam int STAGES = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b1;
  logic                ovf_clr = 1'b0;
  logic signed [W-1:0] a_in = '0;
  logic signed [W-1:0] b_in = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fixed_mult_pipe_if #(.WIDTH(W)) u_if0 ();
  fixed_mult_pipe_if #(.WIDTH(W)) u_if1 ();

  assign u_if0.in_valid  = in_valid;
  assign u_if0.a_in      = a_in;
  assign u_if0.b_in      = b_in;
  assign u_if0.out_ready = out_ready;
  assign u_if0.ovf_clr   = ovf_clr;
  assign u_if1.in_valid  = in_valid;
  assign u_if1.a_in      = a_in;
  assign u_if1.b_in      = b_in;
  assign u_if1.out_ready = out_ready;
  assign u_if1.ovf_clr   = ovf_clr;

  fixed_mult_pipe #(.WIDTH(W), .FRAC_BITS(FRAC), .STAGES(STAGES), .ROUND_EN(1), .SAT_EN(1))
    u_dut_rs (.clk(clk), .rst_n(rst_n), .bus(u_if0));
  fixed_mult_pipe #(.WIDTH(W), .FRAC_BITS(FRAC), .STAGES(STAGES), .ROUND_EN(0), .SAT_EN(0))
    u_dut_tw (.clk(clk), .rst_n(rst_n), .bus(u_if1));

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p_rs;
    logic        o_rs;
    logic [31:0] p_tw;
    logic        o_tw;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Exact rational product, rounded by floor(x + 1/2) or floor(x), then clamped or wrapped.
  function automatic logic [32:0] model(input logic signed [31:0] a, input logic signed [31:0] b,
                                        input bit rnd, input bit sat);
    longint      pr, q;
    logic        ovf;
    logic [31:0] p;
    pr = longint'(a) * longint'(b);
    if (rnd) pr = pr + (longint'(1) <<< (FRAC - 1));
    q   = pr >>> FRAC;
    ovf = (q > 64'sd2147483647) || (q < -64'sd2147483648);
    p   = q[31:0];
    if (ovf && sat) p = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {ovf, p};
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = v.a; b_in = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!u_if0.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, " latency"}, lat, STAGES - 1);
    check({v.name, " p rs"},    u_if0.p_out,   v.p_rs);
    check({v.name, " ovf rs"},  u_if0.ovf_out, v.o_rs);
    check({v.name, " p tw"},    u_if1.p_out,   v.p_tw);
    check({v.name, " ovf tw"},  u_if1.ovf_out, v.o_tw);
  endtask

  task automatic run_stream(input int n, input bit rnd_ops, input bit stall5);
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [32:0] e;
    int          sent;
    int          got;
    bit          took;
    sent = 0; got = 0; took = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 1500 && got < n; cyc++) begin
      @(posedge clk); #1;
      if (took) in_valid = 1'b0;
      took = 1'b0;
      if (stall5 && cyc >= 5 && cyc < 10) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && sent < n && (!rnd_ops || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        if (rnd_ops) begin
          a_in = $urandom();
          b_in = $urandom();
          if ($urandom_range(0, 2) != 0) a_in = a_in >>> $urandom_range(8, 28);
          if ($urandom_range(0, 2) != 0) b_in = b_in >>> $urandom_range(8, 28);
        end else begin
          a_in = sent + 1;
          b_in = 32'h100;
        end
      end
      @(negedge clk);
      check("in_ready vs stall", u_if0.in_ready, !(u_if0.out_valid && !out_ready));
      if (in_valid && u_if0.in_ready) begin
        qa.push_back(a_in);
        qb.push_back(b_in);
        sent++;
        took = 1'b1;
      end
      if (u_if0.out_valid && out_ready) begin
        if (qa.size() == 0) begin
          check("output without input, count", got + 1, sent);
        end else begin
          e = model($signed(qa[0]), $signed(qb[0]), 1'b1, 1'b1);
          check("stream p rs",   u_if0.p_out,   e[31:0]);
          check("stream ovf rs", u_if0.ovf_out, e[32]);
          e = model($signed(qa[0]), $signed(qb[0]), 1'b0, 1'b0);
          check("stream valid tw", u_if1.out_valid, 1);
          check("stream p tw",   u_if1.p_out,   e[31:0]);
          check("stream ovf tw", u_if1.ovf_out, e[32]);
          void'(qa.pop_front());
          void'(qb.pop_front());
          got++;
        end
      end
    end
    check("stream output count", got, n);
    check("stream leftover", qa.size(), 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0] = '{"basic",    32'h0000_0180, 32'h0000_0200, 32'h0000_0300, 1'b0, 32'h0000_0300, 1'b0};
    vecs[1] = '{"rnd_pos",  32'h0000_0001, 32'h0000_0080, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0};
    vecs[2] = '{"rnd_neg",  32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{"sat_pos",  32'h7FFF_FFFF, 32'h0000_0200, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b1};
    vecs[4] = '{"min_min",  32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{"sat_neg",  32'h8000_0000, 32'h0000_0200, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{"neg_two",  32'hFFFF_FF00, 32'h0000_0200, 32'hFFFF_FE00, 1'b0, 32'hFFFF_FE00, 1'b0};
    vecs[7] = '{"max_edge", 32'h7FFF_FFFF, 32'h0000_0100, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0};
    vecs[8] = '{"min_edge", 32'h8000_0000, 32'h0000_0100, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", u_if0.out_valid,  0);
    check("reset p_out",     u_if0.p_out,      0);
    check("reset ovf_out",   u_if0.ovf_out,    0);
    check("reset sticky",    u_if0.ovf_sticky, 0);
    check("reset tw valid",  u_if1.out_valid,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", u_if0.in_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);
    @(posedge clk); #1;
    check("sticky held rs", u_if0.ovf_sticky, 1);
    check("sticky held tw", u_if1.ovf_sticky, 1);

    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("sticky clear rs", u_if0.ovf_sticky, 0);
    check("sticky clear tw", u_if1.ovf_sticky, 0);

    ovf_clr = 1'b1;
    run_vec(vecs[3]);
    check("sticky while clr rs", u_if0.ovf_sticky, 0);
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("sticky set wins rs", u_if0.ovf_sticky, 1);
    check("sticky set wins tw", u_if1.ovf_sticky, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;

    run_stream(8, 1'b0, 1'b1);
    run_stream(200, 1'b1, 1'b0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 32'h7FFF_FFFF;
    b_in      = 32'h0000_0200;
    seen = 0;
    while (!u_if0.out_valid && seen < 10) begin
      @(posedge clk); #1;
      seen++;
    end
    check("pre-reset out_valid", u_if0.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid rs", u_if0.out_valid,  0);
    check("mid reset out_valid tw", u_if1.out_valid,  0);
    check("mid reset p_out",        u_if0.p_out,      0);
    check("mid reset ovf_out",      u_if0.ovf_out,    0);
    check("mid reset sticky",       u_if0.ovf_sticky, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (u_if0.out_valid || u_if1.out_valid) seen++;
    end
    check("no output after reset", seen, 0);
    check("in_ready after mid reset", u_if0.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
